// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer onto a valid/ready data bus
// Stalls the pipeline per access, aligns store lanes, extends load data, bounds each access with a timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_mask,
  input  logic        mem_sext,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        access_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        strb_q, strb_d;
  logic [1:0]        off_q, off_d;
  logic              we_q, we_d;
  logic              sext_q, sext_d;
  logic              word_q, word_d;
  logic              half_q, half_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              access;
  logic              misaligned;
  logic              timed_out;
  logic [31:0]       w;
  logic [31:0]       ext;

  assign access     = mem_read | mem_write;
  // mask[1] covers half and word, mask[3] only word
  assign misaligned = (mem_mask[1] & mem_addr[0]) | (mem_mask[3] & mem_addr[1]);
  assign timed_out  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w   = bus_rsp_rdata >> {off_q, 3'b000};
    ext = w;
    if (word_q)      ext = w;
    else if (half_q) ext = {{16{sext_q & w[15]}}, w[15:0]};
    else             ext = {{24{sext_q & w[7]}}, w[7:0]};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    strb_d  = strb_q;
    off_d   = off_q;
    we_d    = we_q;
    sext_d  = sext_q;
    word_d  = word_q;
    half_d  = half_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          we_d    = mem_write;
          rdata_d = '0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            addr_d  = {mem_addr[31:2], 2'b00};
            wdata_d = mem_wdata << {mem_addr[1:0], 3'b000};
            strb_d  = mem_mask << mem_addr[1:0];
            off_d   = mem_addr[1:0];
            sext_d  = mem_sext;
            word_d  = mem_mask[3];
            half_d  = mem_mask[1];
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_req_ready && we_q) begin
          state_d = DONE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else if (bus_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rsp_valid) begin
          rdata_d = ext;
          state_d = DONE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      word_q  <= 1'b0;
      half_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      strb_q  <= strb_d;
      off_q   <= off_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      word_q  <= word_d;
      half_q  <= half_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall         = ((state_q == IDLE) & access) | (state_q == REQ) | (state_q == RESP);
  assign bus_req_valid = (state_q == REQ);
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_wstrb     = strb_q;
  assign load_valid    = (state_q == DONE) & ~we_q & ~err_q;
  assign access_err    = (state_q == DONE) & err_q;
  assign load_data     = rdata_q;

endmodule
